pdp_mem_ctrl: RTL and testbench
===============================

PDP_MEM_CTRL -- requirements
Module: pdp_mem_ctrl

Interface
REQ-001 Parameter MEM_DEPTH, default 4096, number of words; the address width is fixed at `ADDR_WIDTH (12).
REQ-002 clk  input  1  the single clock; every flop is on the posedge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 ifu_rd_req  input  1  fetch read request from the IFD, held until ifu_rd_vld.
REQ-005 ifu_rd_addr  input  `ADDR_WIDTH  fetch address.
REQ-006 ifu_rd_data  output  `DATA_WIDTH  fetched word.
REQ-007 ifu_rd_vld  output  1  one-cycle pulse: ifu_rd_data is valid.
REQ-008 exec_rd_req / exec_rd_addr  input  1 / `ADDR_WIDTH  execution-unit operand read.
REQ-009 exec_rd_data / exec_rd_vld  output  `DATA_WIDTH / 1  operand data and its valid pulse.
REQ-010 exec_wr_req / exec_wr_addr / exec_wr_data  input  1 / `ADDR_WIDTH / `DATA_WIDTH  execution-unit write.
REQ-011 exec_wr_ack  output  1  one-cycle pulse: the write is committed.
REQ-012 mem_par_err  output  1  parity error flag, valid together with either rd_vld.

Function
REQ-013 The storage SHALL be one single-port MEM_DEPTH x `DATA_WIDTH array, with at most one access per cycle.
REQ-014 The FSM SHALL have the states IDLE, WR_EXEC, RD_EXEC and RD_IFU.
REQ-015 Arbitration priority SHALL be exec_wr_req > exec_rd_req > ifu_rd_req, evaluated in IDLE and in every access state.
REQ-016 The winning request SHALL move the FSM to its access state on the next posedge.
  - With no request pending, the FSM goes to IDLE.
  - Back-to-back accesses SHALL be possible with no IDLE cycle in between.
REQ-017 Read latency SHALL be 1 cycle: a request granted at edge N produces registered data and a vld pulse after edge N+1, for one cycle.
REQ-018 A write granted at edge N SHALL commit at edge N+1, and exec_wr_ack SHALL pulse for that cycle.
REQ-019 A losing request SHALL stay pending with no vld or ack; the requester holds req, addr and data stable until it sees vld or ack.
REQ-020 A read of address A in the cycle after a write to A SHALL return the new data.
REQ-021 Data outputs SHALL hold their last value while vld is low.
REQ-022 A requester that keeps req high after its vld SHALL be treated as a new request.
REQ-023 Addresses at or above MEM_DEPTH SHALL wrap modulo MEM_DEPTH.
REQ-024 A simultaneous exec write and IFU read to the same address SHALL serve the write first, so the IFU read returns the written word.

Reset
REQ-025 While reset is high at a posedge:
  - the FSM SHALL go to IDLE;
  - ifu_rd_vld, exec_rd_vld, exec_wr_ack and mem_par_err SHALL be 0;
  - ifu_rd_data and exec_rd_data SHALL be 0.
REQ-026 Array contents SHALL NOT be cleared by reset.
REQ-027 An access in flight when reset asserts SHALL be dropped: no vld or ack is produced and a pending write is not committed.

Configuration
REQ-028 With MEM_PARITY_EN defined:
  - the array SHALL be `DATA_WIDTH+1 bits wide, storing even parity computed on write;
  - parity SHALL be checked on every read, and mem_par_err SHALL be 1 with the vld pulse on a mismatch;
  - a word never written SHALL be reported as an error only if it is X-free and its parity mismatches.
REQ-029 Without MEM_PARITY_EN, the array SHALL be `DATA_WIDTH bits wide and mem_par_err SHALL be tied to 0.

Structure
REQ-030 pdp8_pkg SHALL hold the following, shared with the IFD and EXEC:
  - `ADDR_WIDTH, `DATA_WIDTH and `START_ADDRESS;
  - the mem_state_e enum {IDLE, WR_EXEC, RD_EXEC, RD_IFU}.
REQ-031 The array SHALL be the sub-module pdp_mem_array (clk, we, addr, wdata, rdata, registered read); pdp_mem_ctrl holds the arbiter, the FSM and the parity logic.

Verification
REQ-032 Reset, then ifu_rd_req with addr 0o200 preloaded with 0o7402 -> ifu_rd_vld high one cycle later with ifu_rd_data = 0o7402, mem_par_err = 0.
REQ-033 Same-cycle exec_wr (0o0300 <- 0o1234) and ifu_rd (0o0300):
  - exec_wr_ack at cycle 1;
  - ifu_rd_vld at cycle 2 with data 0o1234.
REQ-034 exec_rd_req and ifu_rd_req asserted together for 3 cycles -> exec_rd_vld first, then ifu_rd_vld, with no idle gap.
REQ-035 Read addr 0o7777, then addr 0o10000 with MEM_DEPTH=4096 -> the second read returns the word at 0o0000.
REQ-036 Reset asserted in the cycle after a grant of an exec write to 0o0400 -> no ack, and 0o0400 keeps its old value.
REQ-037 With MEM_PARITY_EN, force-flip one stored bit at 0o0500, then read it -> mem_par_err = 1 with exec_rd_vld; without the macro, mem_par_err stays 0.

Source files
------------

// File: rtl/pdp8_pkg.sv
// Shared PDP-8 definitions: machine word/address widths, reset vector and memory FSM states.
// Used by the IFD, EXEC and the memory controller.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif
`ifndef START_ADDRESS
`define START_ADDRESS 12'o0200
`endif

package pdp8_pkg;

  localparam int unsigned ADDR_W = `ADDR_WIDTH;
  localparam int unsigned DATA_W = `DATA_WIDTH;
  localparam logic [ADDR_W-1:0] START_ADDR = `START_ADDRESS;

  typedef enum logic [1:0] {
    IDLE,
    WR_EXEC,
    RD_EXEC,
    RD_IFU
  } mem_state_e;

  // Even parity: the stored bit makes the total number of ones even.
  function automatic logic even_par(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/pdp_mem_array.sv
// Single-port synchronous RAM with registered read; addresses wrap modulo DEPTH.
module pdp_mem_array
  import pdp8_pkg::*;
#(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] idx;

  always_comb begin
    idx = ADDR_W'(32'(addr) % DEPTH);
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/pdp_mem_ctrl.sv
// PDP-8 memory controller: arbitrates EXEC writes, EXEC reads and IFU fetches onto one array.
// Define MEM_PARITY_EN to store an even-parity bit per word and flag mismatches on reads.
module pdp_mem_ctrl
  import pdp8_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ifu_rd_req,
  input  logic [ADDR_W-1:0] ifu_rd_addr,
  output logic [DATA_W-1:0] ifu_rd_data,
  output logic              ifu_rd_vld,
  input  logic              exec_rd_req,
  input  logic [ADDR_W-1:0] exec_rd_addr,
  output logic [DATA_W-1:0] exec_rd_data,
  output logic              exec_rd_vld,
  input  logic              exec_wr_req,
  input  logic [ADDR_W-1:0] exec_wr_addr,
  input  logic [DATA_W-1:0] exec_wr_data,
  output logic              exec_wr_ack,
  output logic              mem_par_err
);

`ifdef MEM_PARITY_EN
  localparam int unsigned ARR_W = DATA_W + 1;
`else
  localparam int unsigned ARR_W = DATA_W;
`endif

  mem_state_e        state_q;
  mem_state_e        state_d;
  logic [ADDR_W-1:0] arr_addr;
  logic              arr_we;
  logic [ARR_W-1:0]  arr_wdata;
  logic [ARR_W-1:0]  arr_rdata;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] ifu_data_q;
  logic [DATA_W-1:0] exec_data_q;

  // The request being served in the current state is masked so it is not granted twice;
  // if it is still high in its vld/ack cycle it counts as a fresh request.
  always_comb begin
    state_d  = IDLE;
    arr_addr = ifu_rd_addr;
    arr_we   = 1'b0;
    if (exec_wr_req && (state_q != WR_EXEC)) begin
      state_d = WR_EXEC;
    end else if (exec_rd_req && (state_q != RD_EXEC)) begin
      state_d = RD_EXEC;
    end else if (ifu_rd_req && (state_q != RD_IFU)) begin
      state_d = RD_IFU;
    end
    case (state_q)
      WR_EXEC: begin
        arr_addr = exec_wr_addr;
        arr_we   = !reset;
      end
      RD_EXEC: arr_addr = exec_rd_addr;
      RD_IFU:  arr_addr = ifu_rd_addr;
      default: arr_addr = ifu_rd_addr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ifu_rd_vld  <= 1'b0;
      exec_rd_vld <= 1'b0;
      exec_wr_ack <= 1'b0;
      ifu_data_q  <= '0;
      exec_data_q <= '0;
    end else begin
      state_q     <= state_d;
      ifu_rd_vld  <= (state_q == RD_IFU);
      exec_rd_vld <= (state_q == RD_EXEC);
      exec_wr_ack <= (state_q == WR_EXEC);
      if (ifu_rd_vld) begin
        ifu_data_q <= rd_word;
      end
      if (exec_rd_vld) begin
        exec_data_q <= rd_word;
      end
    end
  end

  // The array output is shared, so each port shows it only during its own vld pulse.
  assign rd_word      = arr_rdata[DATA_W-1:0];
  assign ifu_rd_data  = ifu_rd_vld  ? rd_word : ifu_data_q;
  assign exec_rd_data = exec_rd_vld ? rd_word : exec_data_q;

`ifdef MEM_PARITY_EN
  logic par_bad;

  assign arr_wdata = {even_par(exec_wr_data), exec_wr_data};

  // An unknown parity sum falls through to the else branch, so unwritten words read clean.
  always_comb begin
    if (^arr_rdata) begin
      par_bad = 1'b1;
    end else begin
      par_bad = 1'b0;
    end
  end

  assign mem_par_err = (ifu_rd_vld || exec_rd_vld) && par_bad;
`else
  assign arr_wdata   = exec_wr_data;
  assign mem_par_err = 1'b0;
`endif

  pdp_mem_array #(
    .DEPTH(MEM_DEPTH),
    .WIDTH(ARR_W)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .addr (arr_addr),
    .wdata(arr_wdata),
    .rdata(arr_rdata)
  );

endmodule

// File: tb/tb_pdp_mem_ctrl.sv
// Directed bench for pdp_mem_ctrl: reset, arbitration order, latency, wrap, reset drop, parity.
module tb_pdp_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ifu_rd_req;
  logic [11:0] ifu_rd_addr;
  logic [11:0] ifu_rd_data;
  logic        ifu_rd_vld;
  logic        exec_rd_req;
  logic [11:0] exec_rd_addr;
  logic [11:0] exec_rd_data;
  logic        exec_rd_vld;
  logic        exec_wr_req;
  logic [11:0] exec_wr_addr;
  logic [11:0] exec_wr_data;
  logic        exec_wr_ack;
  logic        mem_par_err;

  int checks = 0;
  int errors = 0;

`ifdef MEM_PARITY_EN
  localparam logic PAR_EXP = 1'b1;
`else
  localparam logic PAR_EXP = 1'b0;
`endif

  pdp_mem_ctrl #(.MEM_DEPTH(4096)) dut (
    .clk         (clk),
    .reset       (reset),
    .ifu_rd_req  (ifu_rd_req),
    .ifu_rd_addr (ifu_rd_addr),
    .ifu_rd_data (ifu_rd_data),
    .ifu_rd_vld  (ifu_rd_vld),
    .exec_rd_req (exec_rd_req),
    .exec_rd_addr(exec_rd_addr),
    .exec_rd_data(exec_rd_data),
    .exec_rd_vld (exec_rd_vld),
    .exec_wr_req (exec_wr_req),
    .exec_wr_addr(exec_wr_addr),
    .exec_wr_data(exec_wr_data),
    .exec_wr_ack (exec_wr_ack),
    .mem_par_err (mem_par_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_write(input logic [11:0] a, input logic [11:0] d, input string tag);
    int n = 0;
    exec_wr_req  = 1'b1;
    exec_wr_addr = a;
    exec_wr_data = d;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (exec_wr_ack) begin
        n = i;
        break;
      end
    end
    exec_wr_req = 1'b0;
    check({tag, "_ack_lat"}, n, 2);
  endtask

  task automatic exec_read(input logic [11:0] a, input logic [11:0] d, input logic perr,
                           input string tag);
    int n = 0;
    exec_rd_req  = 1'b1;
    exec_rd_addr = a;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (exec_rd_vld) begin
        n = i;
        break;
      end
    end
    check({tag, "_lat"}, n, 2);
    check({tag, "_data"}, exec_rd_data, d);
    check({tag, "_perr"}, mem_par_err, perr);
    exec_rd_req = 1'b0;
  endtask

  task automatic ifu_read(input logic [11:0] a, input logic [11:0] d, input string tag);
    int n = 0;
    ifu_rd_req  = 1'b1;
    ifu_rd_addr = a;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (ifu_rd_vld) begin
        n = i;
        break;
      end
    end
    check({tag, "_lat"}, n, 2);
    check({tag, "_data"}, ifu_rd_data, d);
    check({tag, "_perr"}, mem_par_err, 1'b0);
    ifu_rd_req = 1'b0;
  endtask

  initial begin
    logic [12:0] far_addr;
    reset        = 1'b1;
    ifu_rd_req   = 1'b0;
    ifu_rd_addr  = '0;
    exec_rd_req  = 1'b0;
    exec_rd_addr = '0;
    exec_wr_req  = 1'b0;
    exec_wr_addr = '0;
    exec_wr_data = '0;
    step();
    step();
    reset = 1'b0;
    check("rst_ifu_vld", ifu_rd_vld, 1'b0);
    check("rst_exec_vld", exec_rd_vld, 1'b0);
    check("rst_ack", exec_wr_ack, 1'b0);
    check("rst_perr", mem_par_err, 1'b0);
    check("rst_ifu_data", ifu_rd_data, 12'o0000);
    check("rst_exec_data", exec_rd_data, 12'o0000);

    // Preload, then reset again: contents must survive.
    mem_write(12'o0200, 12'o7402, "pre200");
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst2_ack", exec_wr_ack, 1'b0);
    ifu_read(12'o0200, 12'o7402, "fetch200");
    step();
    check("fetch_vld_pulse", ifu_rd_vld, 1'b0);
    check("fetch_data_hold", ifu_rd_data, 12'o7402);

    // Same-cycle write and fetch to one address: write first, fetch sees new word.
    exec_wr_req  = 1'b1;
    exec_wr_addr = 12'o0300;
    exec_wr_data = 12'o1234;
    ifu_rd_req   = 1'b1;
    ifu_rd_addr  = 12'o0300;
    step();
    check("wf_c0_ack", exec_wr_ack, 1'b0);
    check("wf_c0_ivld", ifu_rd_vld, 1'b0);
    step();
    check("wf_c1_ack", exec_wr_ack, 1'b1);
    check("wf_c1_ivld", ifu_rd_vld, 1'b0);
    exec_wr_req = 1'b0;
    step();
    check("wf_c2_ack", exec_wr_ack, 1'b0);
    check("wf_c2_ivld", ifu_rd_vld, 1'b1);
    check("wf_c2_data", ifu_rd_data, 12'o1234);
    ifu_rd_req = 1'b0;

    // Operand read beats fetch, fetch follows with no gap.
    mem_write(12'o1000, 12'o1111, "pre1000");
    mem_write(12'o1001, 12'o2222, "pre1001");
    exec_rd_req  = 1'b1;
    exec_rd_addr = 12'o1000;
    ifu_rd_req   = 1'b1;
    ifu_rd_addr  = 12'o1001;
    step();
    check("rr_c0_evld", exec_rd_vld, 1'b0);
    check("rr_c0_ivld", ifu_rd_vld, 1'b0);
    step();
    check("rr_c1_evld", exec_rd_vld, 1'b1);
    check("rr_c1_ivld", ifu_rd_vld, 1'b0);
    check("rr_c1_edata", exec_rd_data, 12'o1111);
    exec_rd_req = 1'b0;
    step();
    check("rr_c2_evld", exec_rd_vld, 1'b0);
    check("rr_c2_ivld", ifu_rd_vld, 1'b1);
    check("rr_c2_idata", ifu_rd_data, 12'o2222);
    check("rr_c2_ehold", exec_rd_data, 12'o1111);
    ifu_rd_req = 1'b0;

    // Request held past its vld is served again.
    exec_rd_req  = 1'b1;
    exec_rd_addr = 12'o1000;
    step();
    step();
    check("rep_vld1", exec_rd_vld, 1'b1);
    step();
    check("rep_gap", exec_rd_vld, 1'b0);
    exec_rd_req = 1'b0;
    step();
    check("rep_vld2", exec_rd_vld, 1'b1);
    check("rep_data2", exec_rd_data, 12'o1111);
    step();

    // Top address, then an out-of-range address that wraps to zero.
    mem_write(12'o7777, 12'o4321, "pre7777");
    mem_write(12'o0000, 12'o0123, "pre0000");
    exec_read(12'o7777, 12'o4321, 1'b0, "rd7777");
    far_addr = 13'o10000;
    exec_read(far_addr[11:0], 12'o0123, 1'b0, "rdwrap");

    // Reset in the cycle after a write grant drops the write.
    mem_write(12'o0400, 12'o3333, "pre400");
    exec_wr_req  = 1'b1;
    exec_wr_addr = 12'o0400;
    exec_wr_data = 12'o4444;
    step();
    reset = 1'b1;
    step();
    check("drop_ack_rst", exec_wr_ack, 1'b0);
    exec_wr_req = 1'b0;
    reset       = 1'b0;
    step();
    check("drop_ack_after", exec_wr_ack, 1'b0);
    exec_read(12'o0400, 12'o3333, 1'b0, "drop_rd400");

    // Store 0o2525 with bit 0 flipped on its way into the array.
`ifdef MEM_PARITY_EN
    force dut.arr_wdata = 13'o02524;
`else
    force dut.arr_wdata = 12'o2524;
`endif
    mem_write(12'o0500, 12'o2525, "pre500");
    release dut.arr_wdata;
    exec_read(12'o0500, 12'o2524, PAR_EXP, "par500");
    step();
    check("par_clear", mem_par_err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
